// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_sel.sv
// Fetch PC register: redirect beats sequential increment, targets word-aligned.
module fetch_pc_sel
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc_q,
    output logic              misaligned
);

    // PC update and one-cycle misalignment flag for accepted redirects
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misaligned <= 1'b0;
        end else begin
            misaligned <= redirect && (redirect_pc[1:0] != 2'b00);
            if (redirect) begin
                pc_q <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (advance) begin
                pc_q <= pc_q + PC_INCR;
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding imem request, squashes stale responses on redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instruction_o,
    output logic [31:0] pc_o,
    output logic        misaligned_o
);

    import fetch_pkg::*;

    fetch_state_e      state_q, state_d;
    logic              squash_q, squash_d;
    logic              valid_d;
    logic [DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0] pc_out_d;
    logic [ADDR_W-1:0] pc_q;
    logic              redir_take;
    logic              advance;

    fetch_pc_sel #(
        .RESET_PC(RESET_PC)
    ) u_pc_sel (
        .clk        (clk_i),
        .rst        (rst_i),
        .redirect   (redir_take),
        .redirect_pc(redirect_pc_i),
        .advance    (advance),
        .pc_q       (pc_q),
        .misaligned (misaligned_o)
    );

    // Memory request side is decoded from state and PC only
    assign imem_req_o  = (state_q == REQ);
    assign imem_addr_o = pc_q;

    // State, squash flag and decode-facing output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            squash_q      <= 1'b0;
            instr_valid_o <= 1'b0;
            instruction_o <= NOP_INSTR;
            pc_o          <= RESET_PC;
        end else begin
            state_q       <= state_d;
            squash_q      <= squash_d;
            instr_valid_o <= valid_d;
            instruction_o <= instr_d;
            pc_o          <= pc_out_d;
        end
    end

    // Next-state logic; a redirect overrides every other transition
    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        valid_d    = instr_valid_o;
        instr_d    = instruction_o;
        pc_out_d   = pc_o;
        redir_take = 1'b0;
        advance    = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect_i) begin
                    redir_take = 1'b1;
                    if (imem_gnt_i) begin
                        squash_d = 1'b1;
                        state_d  = WAIT;
                    end
                end else if (imem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_i) begin
                    redir_take = 1'b1;
                    if (imem_rvalid_i) begin
                        squash_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (imem_rvalid_i) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = REQ;
                    end else begin
                        instr_d  = imem_rdata_i;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_i) begin
                    redir_take = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = REQ;
                end else if (instr_ready_i) begin
                    valid_d = 1'b0;
                    advance = 1'b1;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage of the RISC-V core, directly upstream of instruction decode and the immediate generator.
- Holds the PC and issues requests to the instruction memory over a req/gnt + rvalid interface.
- Presents a fetched instruction and its PC to decode with a valid/ready handshake.
- Accepts PC redirects (branches/jumps), including redirects that arrive while a memory request is outstanding.

Parameters:
RESET_PC, 32'h0000_0000, first PC fetched after reset
NOP_INSTR, 32'h0000_0013, instruction_o value at reset/idle (addi x0,x0,0)

Ports:
clk_i  in  1  core clock; all state changes on rising edge
rst_i  in  1  reset, asynchronous, active-high
imem_req_o  out  1  fetch request to instruction memory
imem_addr_o  out  32  fetch address (word aligned)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  read data valid (exactly one per granted request)
imem_rdata_i  in  32  read data
redirect_i  in  1  one-cycle PC redirect strobe
redirect_pc_i  in  32  redirect target
instr_valid_o  out  1  instruction_o/pc_o valid to decode
instr_ready_i  in  1  decode accepts instruction
instruction_o  out  32  fetched instruction (feeds decode/immediate generator)
pc_o  out  32  PC of instruction_o
misaligned_o  out  1  one-cycle pulse: redirect target had bits [1:0] != 0

Behaviour:
- Reset (async, rst_i high):
  - state=IDLE, pc_q=RESET_PC, squash_q=0.
  - Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instruction_o=NOP_INSTR, pc_o=RESET_PC, misaligned_o=0.
  - Reset mid-transaction discards all state; a late imem_rvalid_i after reset is ignored while in IDLE/REQ.
- FSM states IDLE, REQ, WAIT, HOLD:
  - IDLE: unconditionally go to REQ on the first clock after reset deasserts.
  - REQ: imem_req_o=1, imem_addr_o=pc_q. On imem_gnt_i go to WAIT, otherwise stay in REQ.
  - WAIT: imem_req_o=0. On imem_rvalid_i:
    - if squash_q: drop the data, clear squash_q, go to REQ.
    - else: instruction_o<=imem_rdata_i, pc_o<=pc_q, instr_valid_o<=1, go to HOLD.
  - HOLD: outputs are held stable while instr_valid_o && !instr_ready_i. On handshake: instr_valid_o<=0, pc_q<=pc_q+4 (mod 2^32, wraps 0xFFFF_FFFC->0), go to REQ.
- Latency and throughput:
  - Minimum 3 cycles per instruction: REQ (gnt same cycle), WAIT (rvalid next cycle), HOLD (ready same cycle).
  - No prefetch; at most one outstanding request.
- Redirect (redirect_i=1) has priority over all other transitions in the same cycle:
  - Target used is {redirect_pc_i[31:2],2'b00}. misaligned_o pulses high the next cycle if redirect_pc_i[1:0]!=0.
  - IDLE: ignored.
  - REQ without gnt: pc_q<=target, stay in REQ; the next request uses the new address.
  - REQ with gnt same cycle: pc_q<=target, squash_q<=1, go to WAIT.
  - WAIT without rvalid: pc_q<=target, squash_q<=1, stay in WAIT.
  - WAIT with rvalid same cycle: drop the data, pc_q<=target, squash_q<=0, go to REQ.
  - HOLD: instr_valid_o<=0 even if instr_ready_i=1 that cycle, pc_q<=target, go to REQ.
  - Back-to-back redirects: the last one wins; squash_q stays 1 until the outstanding response returns.
- Registered outputs: instr_valid_o, instruction_o, pc_o, misaligned_o. imem_req_o and imem_addr_o are decoded from state/pc_q only, with no combinational path from any input.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_e enum (IDLE, REQ, WAIT, HOLD)
  - NOP_INSTR constant
  - PC_INCR=32'd4 constant
  - ADDR_W=32 constant
- One natural sub-module, fetch_pc_sel: a registered PC with redirect-over-increment priority and alignment masking. It outputs pc_q and the misaligned pulse.

Test Plan:
- Reset release, memory grants immediately and returns 0x00500093 one cycle later, ready=1 -> imem_addr_o=0x0 in REQ, instr_valid_o=1 with instruction_o=0x00500093, pc_o=0x0; next request address 0x4.
- Decode stalls (instr_ready_i=0 for 5 cycles) -> instruction_o/pc_o/instr_valid_o stable; no imem_req_o during the stall; after ready the next address is pc+4.
- redirect_i with target 0x100 while in WAIT; stale rvalid returns 0xDEADBEEF -> data not presented (instr_valid_o stays 0); next request address 0x100.
- redirect_i with target 0x203 in HOLD with instr_ready_i=1 same cycle -> no handshake counted, misaligned_o pulses 1 cycle, next imem_addr_o=0x200.
- gnt withheld 4 cycles, redirect to 0x40 in cycle 2 -> imem_req_o stays high, address switches 0x8->0x40, granted fetch is 0x40.
- PC at 0xFFFF_FFFC completes a handshake -> next address 0x0. Assert rst_i during WAIT -> outputs return to reset values asynchronously.
